// File: rtl/mem_sram_slave.sv
// Word-organised SRAM responder for the write-back data-memory channels.
// Read and write sides are independent FSMs with fixed programmable response latency.
module mem_sram_slave #(
   parameter int          DEPTH  = 1024,
   parameter logic [31:0] BASE   = 32'h8000_0000,
   parameter int          RD_LAT = 1,
   parameter int          WR_LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] mem_araddr,
   input  logic        mem_arvalid,
   output logic        mem_arready,
   output logic [31:0] mem_rdata,
   output logic [1:0]  mem_rresp,
   output logic        mem_rvalid,
   input  logic        mem_rready,
   input  logic [31:0] mem_awaddr,
   input  logic        mem_awvalid,
   output logic        mem_awready,
   input  logic [31:0] mem_wdata,
   input  logic [7:0]  mem_wstrb,
   input  logic        mem_wvalid,
   output logic        mem_wready,
   output logic [1:0]  mem_bresp,
   output logic        mem_bvalid,
   input  logic        mem_bready
);

   // state   | meaning
   // R_IDLE  | arready high, waiting for a read address
   // R_WAIT  | address latched, counting down RD_LAT
   // R_RESP  | rvalid/rdata/rresp held until rready
   // W_IDLE  | collecting AW and W in any order
   // W_WAIT  | both captured, counting down WR_LAT
   // W_RESP  | write committed, bvalid held until bready

   localparam int          IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [31:0] SPAN   = 32'(4 * DEPTH);
   localparam logic [1:0]  OKAY   = 2'b00;
   localparam logic [1:0]  SLVERR = 2'b10;

   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

   r_state_t    r_state;
   w_state_t    w_state;
   logic [15:0] r_cnt;
   logic [15:0] w_cnt;
   logic [31:0] r_addr;
   logic [31:0] aw_addr;
   logic [31:0] w_data;
   logic [3:0]  w_strb;
   logic        aw_got;
   logic        w_got;
   logic        ar_hs;
   logic        aw_hs;
   logic        w_hs;
   logic        commit;
   logic        unused_strb;

   logic [31:0] mem [DEPTH];

   function automatic logic hit(input logic [31:0] a);
      return (a >= BASE) && ((a - BASE) < SPAN);
   endfunction

   function automatic logic [IDX_W-1:0] idx(input logic [31:0] a);
      return IDX_W'((a - BASE) >> 2);
   endfunction

   assign ar_hs       = mem_arvalid && mem_arready;
   assign aw_hs       = mem_awvalid && mem_awready;
   assign w_hs        = mem_wvalid && mem_wready;
   assign unused_strb = &{1'b0, mem_wstrb[7:4]};

   // Commit lands on the same edge bvalid rises; a concurrent read sample sees the old word.
   assign commit = rst && (w_state == W_WAIT) && (w_cnt == '0);

   always_ff @(posedge clk) begin
      if (commit && hit(aw_addr)) begin
         for (int i = 0; i < 4; i++) begin
            if (w_strb[i]) mem[idx(aw_addr)][8*i +: 8] <= w_data[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= R_IDLE;
         r_cnt       <= '0;
         r_addr      <= '0;
         mem_arready <= 1'b0;
         mem_rvalid  <= 1'b0;
         mem_rdata   <= '0;
         mem_rresp   <= OKAY;
      end else begin
         case (r_state)
            R_IDLE: begin
               mem_arready <= 1'b1;
               if (ar_hs) begin
                  r_addr      <= mem_araddr;
                  mem_arready <= 1'b0;
                  r_cnt       <= 16'(RD_LAT);
                  r_state     <= R_WAIT;
               end
            end
            R_WAIT: begin
               if (r_cnt == '0) begin
                  mem_rvalid <= 1'b1;
                  mem_rdata  <= hit(r_addr) ? mem[idx(r_addr)] : '0;
                  mem_rresp  <= hit(r_addr) ? OKAY : SLVERR;
                  r_state    <= R_RESP;
               end else begin
                  r_cnt <= r_cnt - 16'd1;
               end
            end
            R_RESP: begin
               if (mem_rready) begin
                  mem_rvalid  <= 1'b0;
                  mem_rdata   <= '0;
                  mem_arready <= 1'b1;
                  r_state     <= R_IDLE;
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         w_state     <= W_IDLE;
         w_cnt       <= '0;
         aw_addr     <= '0;
         w_data      <= '0;
         w_strb      <= '0;
         aw_got      <= 1'b0;
         w_got       <= 1'b0;
         mem_awready <= 1'b0;
         mem_wready  <= 1'b0;
         mem_bvalid  <= 1'b0;
         mem_bresp   <= OKAY;
      end else begin
         case (w_state)
            W_IDLE: begin
               mem_awready <= !(aw_got || aw_hs);
               mem_wready  <= !(w_got || w_hs);
               if (aw_hs) begin
                  aw_addr <= mem_awaddr;
                  aw_got  <= 1'b1;
               end
               if (w_hs) begin
                  w_data <= mem_wdata;
                  w_strb <= mem_wstrb[3:0];
                  w_got  <= 1'b1;
               end
               if ((aw_got || aw_hs) && (w_got || w_hs)) begin
                  aw_got  <= 1'b0;
                  w_got   <= 1'b0;
                  w_cnt   <= 16'(WR_LAT);
                  w_state <= W_WAIT;
               end
            end
            W_WAIT: begin
               if (w_cnt == '0) begin
                  mem_bvalid <= 1'b1;
                  mem_bresp  <= hit(aw_addr) ? OKAY : SLVERR;
                  w_state    <= W_RESP;
               end else begin
                  w_cnt <= w_cnt - 16'd1;
               end
            end
            W_RESP: begin
               if (mem_bready) begin
                  mem_bvalid  <= 1'b0;
                  mem_awready <= 1'b1;
                  mem_wready  <= 1'b1;
                  w_state     <= W_IDLE;
               end
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_sram_slave.sv
// Directed bench for mem_sram_slave with default parameters (RD_LAT=WR_LAT=1).
module tb_mem_sram_slave;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] mem_araddr;
   logic        mem_arvalid;
   logic        mem_arready;
   logic [31:0] mem_rdata;
   logic [1:0]  mem_rresp;
   logic        mem_rvalid;
   logic        mem_rready;
   logic [31:0] mem_awaddr;
   logic        mem_awvalid;
   logic        mem_awready;
   logic [31:0] mem_wdata;
   logic [7:0]  mem_wstrb;
   logic        mem_wvalid;
   logic        mem_wready;
   logic [1:0]  mem_bresp;
   logic        mem_bvalid;
   logic        mem_bready;

   int tests = 0;
   int fails = 0;

   mem_sram_slave dut (
      .clk(clk), .rst(rst),
      .mem_araddr(mem_araddr), .mem_arvalid(mem_arvalid), .mem_arready(mem_arready),
      .mem_rdata(mem_rdata), .mem_rresp(mem_rresp), .mem_rvalid(mem_rvalid), .mem_rready(mem_rready),
      .mem_awaddr(mem_awaddr), .mem_awvalid(mem_awvalid), .mem_awready(mem_awready),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
      .mem_bresp(mem_bresp), .mem_bvalid(mem_bvalid), .mem_bready(mem_bready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_b(output int lat);
      lat = 0;
      while (mem_bvalid !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
   endtask

   task automatic wait_r(output int lat);
      lat = 0;
      while (mem_rvalid !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [7:0] s,
                           output logic [1:0] resp, output int lat);
      mem_awaddr  = a;
      mem_wdata   = d;
      mem_wstrb   = s;
      mem_awvalid = 1'b1;
      mem_wvalid  = 1'b1;
      tick();
      mem_awvalid = 1'b0;
      mem_wvalid  = 1'b0;
      wait_b(lat);
      resp = mem_bresp;
      tick();
      chk("b_drop", 32'(mem_bvalid), 32'd0);
      chk("w_ready_back", 32'({mem_awready, mem_wready}), 32'd3);
   endtask

   task automatic do_read(input logic [31:0] a, output logic [31:0] d,
                          output logic [1:0] resp, output int lat);
      mem_araddr  = a;
      mem_arvalid = 1'b1;
      tick();
      mem_arvalid = 1'b0;
      wait_r(lat);
      d    = mem_rdata;
      resp = mem_rresp;
      tick();
      chk("r_drop", 32'({mem_rvalid, mem_arready}), 32'd1);
      chk("rdata_clear", mem_rdata, 32'd0);
   endtask

   initial begin
      logic [31:0] d;
      logic [1:0]  resp;
      int          lat;

      rst = 1'b0;
      mem_araddr = 32'h8000_0000; mem_arvalid = 1'b1; mem_rready = 1'b1;
      mem_awaddr = 32'h8000_0010; mem_awvalid = 1'b1; mem_bready = 1'b1;
      mem_wdata  = 32'h1234_5678; mem_wstrb = 8'h0F;  mem_wvalid = 1'b1;

      // reset with all valids high
      repeat (5) tick();
      chk("rst_readies", 32'({mem_arready, mem_awready, mem_wready}), 32'd0);
      chk("rst_valids", 32'({mem_rvalid, mem_bvalid}), 32'd0);
      chk("rst_rdata", mem_rdata, 32'd0);
      chk("rst_resps", 32'({mem_rresp, mem_bresp}), 32'd0);
      mem_arvalid = 1'b0; mem_awvalid = 1'b0; mem_wvalid = 1'b0;
      rst = 1'b1;
      tick();
      chk("release_readies", 32'({mem_arready, mem_awready, mem_wready}), 32'd7);

      // write then read, unaligned read address
      do_write(32'h8000_0010, 32'hDEAD_BEEF, 8'h0F, resp, lat);
      chk("wr1_bresp", 32'(resp), 32'd0);
      chk("wr1_lat", 32'(lat), 32'd2);
      do_read(32'h8000_0013, d, resp, lat);
      chk("rd1_data", d, 32'hDEAD_BEEF);
      chk("rd1_rresp", 32'(resp), 32'd0);
      chk("rd1_lat", 32'(lat), 32'd2);

      // byte strobes
      do_write(32'h8000_0010, 32'h0000_1200, 8'h02, resp, lat);
      do_read(32'h8000_0010, d, resp, lat);
      chk("strb_byte1", d, 32'hDEAD_12EF);
      do_write(32'h8000_0010, 32'hFFFF_FFFF, 8'hF0, resp, lat);
      chk("strb_hi_bresp", 32'(resp), 32'd0);
      do_read(32'h8000_0010, d, resp, lat);
      chk("strb_hi_ignored", d, 32'hDEAD_12EF);

      // W three cycles before AW, then bready held low
      mem_bready = 1'b0;
      mem_wdata  = 32'hCAFE_0000; mem_wstrb = 8'h0C; mem_wvalid = 1'b1;
      tick();
      mem_wdata = 32'h1111_1111; mem_wstrb = 8'h0F;
      chk("split_w_only", 32'({mem_awready, mem_wready}), 32'd2);
      tick();
      tick();
      mem_awaddr = 32'h8000_0010; mem_awvalid = 1'b1;
      chk("split_no_b_yet", 32'(mem_bvalid), 32'd0);
      tick();
      mem_awvalid = 1'b0; mem_wvalid = 1'b0;
      chk("split_aw_taken", 32'({mem_awready, mem_wready}), 32'd0);
      wait_b(lat);
      chk("split_lat", 32'(lat), 32'd2);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("bp_hold", 32'({mem_bvalid, mem_bresp}), 32'h4);
      end
      mem_bready = 1'b1;
      tick();
      chk("bp_release", 32'({mem_bvalid, mem_awready, mem_wready}), 32'd3);
      do_read(32'h8000_0010, d, resp, lat);
      chk("split_data", d, 32'hCAFE_12EF);

      // range boundaries
      do_write(32'h8000_0000, 32'hA5A5_A5A5, 8'h0F, resp, lat);
      do_write(32'h8000_0FFC, 32'h0BAD_F00D, 8'h0F, resp, lat);
      chk("last_word_bresp", 32'(resp), 32'd0);
      do_read(32'h7FFF_FFFC, d, resp, lat);
      chk("oor_low_rresp", 32'(resp), 32'd2);
      chk("oor_low_rdata", d, 32'd0);
      do_write(32'h8000_1000, 32'h5555_5555, 8'h0F, resp, lat);
      chk("oor_high_bresp", 32'(resp), 32'd2);
      do_read(32'h8000_1000, d, resp, lat);
      chk("oor_high_rresp", 32'(resp), 32'd2);
      do_read(32'h8000_0000, d, resp, lat);
      chk("word0_intact", d, 32'hA5A5_A5A5);
      do_read(32'h8000_0FFC, d, resp, lat);
      chk("last_word", d, 32'h0BAD_F00D);

      // concurrent read sample and write commit on the same edge
      mem_araddr = 32'h8000_0010; mem_arvalid = 1'b1;
      mem_awaddr = 32'h8000_0010; mem_awvalid = 1'b1;
      mem_wdata  = 32'h0102_0304; mem_wstrb = 8'h0F; mem_wvalid = 1'b1;
      tick();
      mem_arvalid = 1'b0; mem_awvalid = 1'b0; mem_wvalid = 1'b0;
      tick();
      tick();
      chk("conc_valids", 32'({mem_rvalid, mem_bvalid}), 32'd3);
      chk("conc_old_data", mem_rdata, 32'hCAFE_12EF);
      tick();
      do_read(32'h8000_0010, d, resp, lat);
      chk("conc_committed", d, 32'h0102_0304);

      // reset while a read is in R_WAIT, with a write offered during reset
      mem_araddr = 32'h8000_0010; mem_arvalid = 1'b1;
      tick();
      mem_arvalid = 1'b0;
      rst = 1'b0;
      mem_arvalid = 1'b1; mem_awvalid = 1'b1; mem_wvalid = 1'b1;
      mem_wdata = 32'hBAD0_BAD0;
      tick();
      chk("mid_rst_out", 32'({mem_rvalid, mem_arready}), 32'd0);
      repeat (3) tick();
      chk("mid_rst_hold", 32'({mem_rvalid, mem_bvalid}), 32'd0);
      mem_arvalid = 1'b0; mem_awvalid = 1'b0; mem_wvalid = 1'b0;
      rst = 1'b1;
      tick();
      chk("mid_rst_release", 32'({mem_arready, mem_awready, mem_wready}), 32'd7);
      tick();
      tick();
      chk("mid_rst_no_resp", 32'({mem_rvalid, mem_bvalid}), 32'd0);
      do_read(32'h8000_0010, d, resp, lat);
      chk("mid_rst_intact", d, 32'h0102_0304);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
